// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared encodings and helpers for the iterative divider
package iterative_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h80000000;

  // Two's complement negate; INT_MIN maps to itself, which is exactly the
  // unsigned magnitude the datapath wants.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Magnitude of a signed operand, read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/iterative_divider_div_trial_step.sv
// rtl/iterative_divider_div_trial_step.sv - one restoring radix-2 shift/trial-subtract/select step
module div_trial_step
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH-1:0] w_shift_quo;
  logic [WIDTH:0]   w_trial;
  logic             w_keep;

  // Shift the {remainder, quotient} pair, subtract the zero-extended divisor
  // and keep the difference only when it did not borrow. A set extension bit
  // on the incoming remainder would mean the shifted value already exceeds
  // any divisor, so it also forces the keep path.
  always_comb begin
    w_shift_rem = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
    w_shift_quo = {i_quo[WIDTH-2:0], 1'b0};
    w_trial     = w_shift_rem - {1'b0, i_div};
    w_keep      = ~w_trial[WIDTH] | i_rem[WIDTH];
    o_rem       = w_keep ? w_trial : w_shift_rem;
    o_quo       = {w_shift_quo[WIDTH-1:1], w_keep};
  end

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle signed 32-bit restoring divider with sign fix-up
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_ovf;

  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_b_zero;
  logic             w_ovf;

  div_trial_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_next),
    .o_quo (w_quo_next)
  );

  // Start-time classification of the incoming operands.
  always_comb begin
    w_b_zero = (data_operandB == '0);
    w_ovf    = (data_operandA == INT_MIN) && (data_operandB == '1);
  end

  // Control FSM with the iteration datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_div          <= '0;
      r_sign_q       <= 1'b0;
      r_sign_r       <= 1'b0;
      r_ovf          <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ctrl_DIV) begin
            r_sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_sign_r <= data_operandA[WIDTH-1];
            r_ovf    <= w_ovf;
            r_quo    <= abs32(data_operandA);
            r_div    <= abs32(data_operandB);
            r_rem    <= '0;
            r_cnt    <= '0;
            if (w_b_zero) begin
              // Divide-by-zero completes immediately without iterating.
              r_state        <= S_DONE;
              data_result    <= '0;
              data_remainder <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
            r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          // INT_MIN / -1 leaves the magnitude 0x80000000 unnegated, which is
          // the wrapped result; only the exception flag marks it.
          data_result    <= r_sign_q ? neg32(r_quo) : r_quo;
          data_remainder <= r_sign_r ? neg32(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
          data_exception <= r_ovf;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          r_state        <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
